// File: rtl/csr_file.sv
// Machine-mode CSR file with interrupt acceptance, trap entry and mret return.
module csr_file #(
   parameter int unsigned XLEN = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [11:0]       csr_addr,
   input  logic [XLEN-1:0]   csr_wdata,
   input  logic [XLEN-1:0]   pc,
   input  logic              csr_rd,
   input  logic              csr_wr,
   input  logic              is_mret,
   input  logic              timer_irq,
   input  logic              ext_irq,
   output logic [XLEN-1:0]   csr_rdata,
   output logic              epc_taken,
   output logic [XLEN-1:0]   epc
);

   localparam int unsigned CAUSE_W = 4;

   localparam logic [11:0] ADDR_MSTATUS = 12'h300;
   localparam logic [11:0] ADDR_MIE     = 12'h304;
   localparam logic [11:0] ADDR_MTVEC   = 12'h305;
   localparam logic [11:0] ADDR_MEPC    = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
   localparam logic [11:0] ADDR_MIP     = 12'h344;

   localparam logic [CAUSE_W-1:0] CAUSE_TIMER = CAUSE_W'(7);
   localparam logic [CAUSE_W-1:0] CAUSE_EXT   = CAUSE_W'(11);

   // mstatus.MIE doubles as the RUN (1) / MASKED (0) state of the unit
   logic              mstatus_mie;
   logic              mstatus_mpie;
   logic              mie_mtie;
   logic              mie_meie;
   logic [XLEN-1:0]   mtvec;
   logic [XLEN-1:0]   mepc;
   logic [XLEN-1:0]   mcause;
   logic              mip_mtip;
   logic              mip_meip;

   logic              ext_pend;
   logic              tmr_pend;
   logic              irq;
   logic              trap;
   logic [CAUSE_W-1:0] cause;
   logic [XLEN-1:0]   tvec_base;

   // Interrupt arbitration: external beats timer, mret beats both
   always_comb begin
      ext_pend  = mip_meip & mie_meie;
      tmr_pend  = mip_mtip & mie_mtie;
      irq       = mstatus_mie & (ext_pend | tmr_pend);
      trap      = irq & ~is_mret;
      cause     = ext_pend ? CAUSE_EXT : CAUSE_TIMER;
      tvec_base = {mtvec[XLEN-1:2], 2'b00};
   end

   // Redirect target, held low while in reset
   always_comb begin
      epc_taken = 1'b0;
      epc       = '0;
      if (rst_n) begin
         if (is_mret) begin
            epc_taken = 1'b1;
            epc       = mepc;
         end else if (trap) begin
            epc_taken = 1'b1;
            epc       = mtvec[0] ? tvec_base + (XLEN'(cause) << 2) : tvec_base;
         end
      end
   end

   // Read mux; reflects pre-edge state
   always_comb begin
      csr_rdata = '0;
      if (rst_n && csr_rd) begin
         case (csr_addr)
            ADDR_MSTATUS: csr_rdata = XLEN'({mstatus_mpie, 3'b000, mstatus_mie, 3'b000});
            ADDR_MIE:     csr_rdata = XLEN'({mie_meie, 3'b000, mie_mtie, 7'b0000000});
            ADDR_MTVEC:   csr_rdata = mtvec;
            ADDR_MEPC:    csr_rdata = mepc;
            ADDR_MCAUSE:  csr_rdata = mcause;
            ADDR_MIP:     csr_rdata = XLEN'({mip_meip, 3'b000, mip_mtip, 7'b0000000});
            default:      csr_rdata = '0;
         endcase
      end
   end

   // Sample the level interrupt requests into mip
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mip_mtip <= 1'b0;
         mip_meip <= 1'b0;
      end else begin
         mip_mtip <= timer_irq;
         mip_meip <= ext_irq;
      end
   end

   // Architectural CSR update: mret, then trap entry, then software write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mstatus_mie  <= 1'b0;
         mstatus_mpie <= 1'b0;
         mie_mtie     <= 1'b0;
         mie_meie     <= 1'b0;
         mtvec        <= '0;
         mepc         <= '0;
         mcause       <= '0;
      end else if (is_mret) begin
         mstatus_mie  <= mstatus_mpie;
         mstatus_mpie <= 1'b1;
      end else if (trap) begin
         mepc         <= pc & ~XLEN'(3);
         mcause       <= {1'b1, (XLEN-1)'(cause)};
         mstatus_mpie <= mstatus_mie;
         mstatus_mie  <= 1'b0;
      end else if (csr_wr) begin
         case (csr_addr)
            ADDR_MSTATUS: begin
               mstatus_mie  <= csr_wdata[3];
               mstatus_mpie <= csr_wdata[7];
            end
            ADDR_MIE: begin
               mie_mtie <= csr_wdata[7];
               mie_meie <= csr_wdata[11];
            end
            ADDR_MTVEC:  mtvec  <= csr_wdata & ~XLEN'(2);
            ADDR_MEPC:   mepc   <= csr_wdata & ~XLEN'(3);
            ADDR_MCAUSE: mcause <= csr_wdata;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_csr_file.sv
// Directed self-checking bench for csr_file.
module tb_csr_file;

   logic        clk;
   logic        rst_n;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata;
   logic [31:0] pc;
   logic        csr_rd;
   logic        csr_wr;
   logic        is_mret;
   logic        timer_irq;
   logic        ext_irq;
   logic [31:0] csr_rdata;
   logic        epc_taken;
   logic [31:0] epc;

   int n_cmp;
   int n_err;

   csr_file #(.XLEN(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .csr_addr  (csr_addr),
      .csr_wdata (csr_wdata),
      .pc        (pc),
      .csr_rd    (csr_rd),
      .csr_wr    (csr_wr),
      .is_mret   (is_mret),
      .timer_irq (timer_irq),
      .ext_irq   (ext_irq),
      .csr_rdata (csr_rdata),
      .epc_taken (epc_taken),
      .epc       (epc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // advance to 1 time unit after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
      csr_addr = a;
      csr_rd   = 1'b1;
      #1;
      check(tag, csr_rdata, exp);
      csr_rd   = 1'b0;
   endtask

   // one-cycle CSR write
   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      csr_addr  = a;
      csr_wdata = d;
      csr_wr    = 1'b1;
      tick();
      csr_wr    = 1'b0;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      csr_addr = '0; csr_wdata = '0; pc = '0;
      csr_rd = 1'b0; csr_wr = 1'b0; is_mret = 1'b0;
      timer_irq = 1'b0; ext_irq = 1'b0;

      // reset holds outputs low regardless of strobes
      #2;
      is_mret = 1'b1;
      csr_rd  = 1'b1;
      csr_addr = 12'h305;
      #1;
      check("rst_epc_taken", 32'(epc_taken), 32'h0);
      check("rst_rdata", csr_rdata, 32'h0);
      is_mret = 1'b0;
      csr_rd  = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      rd("rst_mstatus", 12'h300, 32'h0);
      rd("rst_mie",     12'h304, 32'h0);
      rd("rst_mtvec",   12'h305, 32'h0);
      rd("rst_mepc",    12'h341, 32'h0);
      tick();
      rd("rst_mcause",  12'h342, 32'h0);
      rd("rst_mip",     12'h344, 32'h0);
      rd("rst_unmapped",12'h7C0, 32'h0);
      tick();

      // write all ones and check masks
      wr(12'h300, 32'hFFFF_FFFF);
      wr(12'h304, 32'hFFFF_FFFF);
      wr(12'h305, 32'hFFFF_FFFF);
      wr(12'h341, 32'hFFFF_FFFF);
      wr(12'h344, 32'hFFFF_FFFF);
      wr(12'h7C0, 32'hFFFF_FFFF);
      rd("mask_mstatus", 12'h300, 32'h0000_0088);
      rd("mask_mie",     12'h304, 32'h0000_0880);
      rd("mask_mtvec",   12'h305, 32'hFFFF_FFFD);
      rd("mask_mepc",    12'h341, 32'hFFFF_FFFC);
      tick();
      rd("mask_mip",     12'h344, 32'h0);
      rd("mask_unmapped",12'h7C0, 32'h0);
      check("no_irq_taken", 32'(epc_taken), 32'h0);

      // direct-mode timer trap
      wr(12'h305, 32'h0000_0100);
      pc = 32'h0000_0040;
      timer_irq = 1'b1;
      #1;
      check("irq_not_yet", 32'(epc_taken), 32'h0);
      tick();
      check("tmr_taken", 32'(epc_taken), 32'h1);
      check("tmr_epc", epc, 32'h0000_0100);
      // write in the trap cycle is suppressed
      csr_addr  = 12'h305;
      csr_wdata = 32'h0000_0200;
      csr_wr    = 1'b1;
      tick();
      csr_wr    = 1'b0;
      rd("tmr_mepc",    12'h341, 32'h0000_0040);
      rd("tmr_mcause",  12'h342, 32'h8000_0007);
      rd("tmr_mstatus", 12'h300, 32'h0000_0080);
      rd("tmr_mtvec_kept", 12'h305, 32'h0000_0100);
      check("masked_no_trap", 32'(epc_taken), 32'h0);

      // mret with the timer still pending
      is_mret = 1'b1;
      #1;
      check("mret_taken", 32'(epc_taken), 32'h1);
      check("mret_epc", epc, 32'h0000_0040);
      tick();
      is_mret = 1'b0;
      rd("mret_mstatus", 12'h300, 32'h0000_0088);
      check("retrap_taken", 32'(epc_taken), 32'h1);
      check("retrap_epc", epc, 32'h0000_0100);
      tick();
      rd("retrap_mstatus", 12'h300, 32'h0000_0080);
      tick();

      // vectored mode, external wins over timer
      wr(12'h305, 32'h0000_0101);
      ext_irq = 1'b1;
      pc = 32'h0000_0083;
      tick();
      check("masked_ext", 32'(epc_taken), 32'h0);
      wr(12'h300, 32'h0000_0008);
      check("vec_taken", 32'(epc_taken), 32'h1);
      check("vec_epc", epc, 32'h0000_012C);
      tick();
      rd("vec_mcause",  12'h342, 32'h8000_000B);
      rd("vec_mepc",    12'h341, 32'h0000_0080);
      rd("vec_mstatus", 12'h300, 32'h0000_0080);

      // requests cleared before return: nothing taken after mret
      timer_irq = 1'b0;
      ext_irq   = 1'b0;
      tick();
      is_mret = 1'b1;
      #1;
      check("mret2_epc", epc, 32'h0000_0080);
      tick();
      is_mret = 1'b0;
      rd("mret2_mstatus", 12'h300, 32'h0000_0088);
      check("cleared_no_trap", 32'(epc_taken), 32'h0);

      // reset in the middle of a pending redirect
      timer_irq = 1'b1;
      tick();
      check("pre_rst_taken", 32'(epc_taken), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_taken", 32'(epc_taken), 32'h0);
      timer_irq = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      rd("post_rst_mtvec",   12'h305, 32'h0);
      rd("post_rst_mstatus", 12'h300, 32'h0);
      rd("post_rst_mie",     12'h304, 32'h0);
      check("post_rst_taken", 32'(epc_taken), 32'h0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // watchdog so the bench always ends
   initial begin
      #20000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/csr_file.md
# csr_file

Machine-mode CSR register file and interrupt/trap unit for the 3-stage RV32I pipeline. It sits beside the execute/writeback stage and consumes the decoder's `csr_rd`, `csr_wr` and `is_mret` strobes together with the CSR address, write data and PC of the instruction in that stage. It returns CSR read data for the writeback mux (`sel_wb = 2'b11`) and produces the redirect target for trap entry and `mret` return. It owns `mstatus`, `mie`, `mtvec`, `mepc`, `mcause` and `mip`, and decides interrupt acceptance every cycle.

## Interface
- `XLEN`, 32, datapath width; only 32 is supported.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `csr_addr`  in  12  CSR address (instruction bits [31:20]).
- `csr_wdata`  in  XLEN  write data (rs1 value).
- `pc`  in  XLEN  PC of the instruction in this stage.
- `csr_rd`  in  1  CSR read strobe from the decoder.
- `csr_wr`  in  1  CSR write strobe from the decoder.
- `is_mret`  in  1  the instruction in this stage is `mret`.
- `timer_irq`  in  1  level machine-timer interrupt request.
- `ext_irq`  in  1  level machine-external interrupt request.
- `csr_rdata`  out  XLEN  CSR read data (combinational).
- `epc_taken`  out  1  redirect PC this cycle and flush younger instructions.
- `epc`  out  XLEN  redirect target, valid when `epc_taken = 1`.

## Operation
- **CSR map:**
  - `mstatus` 0x300: only MIE[3] and MPIE[7] are implemented; other bits read 0.
  - `mie` 0x304: only MTIE[7] and MEIE[11] are implemented.
  - `mtvec` 0x305: bit 1 is hardwired 0. Mode = bit 0 (0 direct, 1 vectored).
  - `mepc` 0x341: bits [1:0] are hardwired 0.
  - `mcause` 0x342: full 32-bit register.
  - `mip` 0x344: read-only. MTIP[7] and MEIP[11] are the registered `timer_irq` and `ext_irq`.
  - Unmapped addresses read 0; writes to them are ignored. Writes to `mip` are ignored.
- **Read:** `csr_rdata` is the selected CSR when `csr_rd = 1`, otherwise 0. It always reflects pre-edge values (read-before-write within a cycle).
- **Write:** when `csr_wr = 1` and no trap is taken, the addressed CSR takes `csr_wdata` at the edge, masked to its implemented bits.
- **Interrupt pending:**
  - `irq = MIE & ((MEIP & MEIE) | (MTIP & MTIE))`.
  - External has priority over timer: cause 11 for external, cause 7 for timer.
- **Trap entry** (`irq = 1` and `is_mret = 0`):
  - Combinationally: `epc_taken = 1`, and `epc = {mtvec[31:2], 2'b00}` in direct mode or `{mtvec[31:2], 2'b00} + 4*cause` in vectored mode.
  - At the edge: `mepc <= pc` with bits [1:0] cleared, `mcause <= {1'b1, 31'(cause)}`, `MPIE <= MIE`, `MIE <= 0`.
  - The CSR write of the interrupted instruction is suppressed; that instruction re-executes after return.
- **mret** (`is_mret = 1`):
  - Combinationally: `epc_taken = 1`, `epc = mepc`.
  - At the edge: `MIE <= MPIE`, `MPIE <= 1`.
- **mret and irq in the same cycle:** `mret` wins. The interrupt is re-evaluated next cycle with the restored MIE.
- **Defined states:** RUN (MIE = 1) and MASKED (MIE = 0).
  - RUN → MASKED on trap entry, or on a `mstatus` write with bit 3 = 0.
  - MASKED → RUN on `mret` with MPIE = 1, or on a `mstatus` write with bit 3 = 1.

## Timing
- **Reset (rst_n low):**
  - All CSRs clear to 0 asynchronously, including the `mip` sample flops.
  - `epc_taken = 0` and `csr_rdata = 0`, regardless of the other inputs.
- **Interrupt latency:** `timer_irq`/`ext_irq` are sampled into `mip` at an edge. `epc_taken` can rise in the cycle after that edge, so acceptance is 1 cycle after the request is first seen high.
- **Redirect:** `epc_taken` and `epc` are combinational in the same cycle as the causing condition. Architectural state updates at the following edge.
- **Write-then-read:** a value written at edge N is visible on `csr_rdata` from cycle N+1.
  - Enabling MIE by CSR write takes effect for interrupts from the next cycle.
- **Deassertion:** if `irq` deasserts before it is accepted, nothing is taken. A level that is cleared by software stops generating traps once `mip` resamples it low.
- **Reset mid-trap:** reset dominates. The pending redirect is dropped and the CSRs return to 0.

## Test plan
- Reset, then read each CSR address 0x300/0x304/0x305/0x341/0x342/0x344 plus unmapped 0x7C0 → all return 0x0000_0000.
- Write 0xFFFF_FFFF to `mstatus`, `mie`, `mtvec` and `mepc`, then read back → 0x0000_0088, 0x0000_0880, 0xFFFF_FFFD and 0xFFFF_FFFC.
- `mtvec = 0x100`, MIE = 1, MTIE = 1, `pc = 0x40`, assert `timer_irq` → next cycle `epc_taken = 1` and `epc = 0x100`; after the edge `mepc = 0x40`, `mcause = 0x8000_0007`, MIE = 0, MPIE = 1.
- `mtvec = 0x101`, both interrupts enabled, `timer_irq` and `ext_irq` asserted together → `epc = 0x12C` and `mcause = 0x8000_000B`.
- After a trap, `is_mret = 1` with `timer_irq` still high → `epc = 0x40` that cycle and MIE = 1 after the edge; the timer trap is taken in the next cycle.
- Trap taken while `csr_wr = 1` targets `mtvec` with 0x200 → `mtvec` stays 0x100. Also assert `rst_n = 0` mid-cycle while `epc_taken = 1` → `epc_taken` drops to 0 immediately.
